// File: rtl/decode_stage_if.sv
// Fetch, writeback and ID/EX bundle for decode_stage.
// The master side belongs to the surrounding pipeline; decode_stage uses slave.
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int PC_W   = 32
);
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [PC_W-1:0]   if_pc;
    logic              flush;
    logic              wb_en;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              id_valid;
    logic              ex_ready;
    logic [5:0]        id_opcode;
    logic [5:0]        id_funct;
    logic [4:0]        id_shamt;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic [RA_W-1:0]   id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [PC_W-1:0]   id_jump;
    logic [PC_W-1:0]   id_branch;

    modport master (
        output if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data, ex_ready,
        input  if_ready, id_valid, id_opcode, id_funct, id_shamt, id_rs, id_rt, id_rd,
        input  id_rs_data, id_rt_data, id_imm, id_jump, id_branch
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data, ex_ready,
        output if_ready, id_valid, id_opcode, id_funct, id_shamt, id_rs, id_rt, id_rd,
        output id_rs_data, id_rt_data, id_imm, id_jump, id_branch
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-I decode stage with register file, ID/EX register and load-use bubble.
// Define RF_BYPASS_EN to write-through same-cycle writeback data into the operands.
//
// state    | meaning
// ST_EMPTY | ID/EX holds nothing valid
// ST_VALID | ID/EX holds a non-load instruction
// ST_LOAD  | ID/EX holds a load (may stall a dependent successor)
module decode_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int RA_W     = 5,
    parameter int PC_W     = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_LOAD  = 2'd2
    } stage_t;

    stage_t state, state_nxt;

    logic [31:0]       instr;
    logic [5:0]        opc;
    logic [RA_W-1:0]   rs_a, rt_a, rd_a;
    logic [DATA_W-1:0] rs_rd, rt_rd, rs_cap, rt_cap;
    logic [DATA_W-1:0] imm_nxt;
    logic [PC_W-1:0]   pc4, jump_nxt, branch_nxt;
    logic              zext, new_is_load;
    logic              valid, is_load, ld, haz, ready, take;

    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    logic [5:0]        opcode_q, funct_q;
    logic [4:0]        shamt_q;
    logic [RA_W-1:0]   rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [PC_W-1:0]   jump_q, branch_q;

    assign instr       = bus.if_instr;
    assign opc         = instr[31:26];
    assign rs_a        = instr[21 +: RA_W];
    assign rt_a        = instr[16 +: RA_W];
    assign rd_a        = instr[11 +: RA_W];
    assign new_is_load = (instr[31:29] == 3'b100);

    // Register 0 has no storage: writes to it match no entry and reads fall to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (bus.wb_addr == RA_W'(i)) begin
                    regs[i] <= bus.wb_data;
                end
            end
        end
    end

    always_comb begin
        rs_rd = '0;
        rt_rd = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs_a == RA_W'(i)) rs_rd = regs[i];
            if (rt_a == RA_W'(i)) rt_rd = regs[i];
        end
    end

`ifdef RF_BYPASS_EN
    logic hit_rs, hit_rt;
    assign hit_rs = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rs_a);
    assign hit_rt = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rt_a);
    assign rs_cap = hit_rs ? bus.wb_data : rs_rd;
    assign rt_cap = hit_rt ? bus.wb_data : rt_rd;
`else
    assign rs_cap = rs_rd;
    assign rt_cap = rt_rd;
`endif

    // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
    assign zext    = (opc == 6'h0C) || (opc == 6'h0D) || (opc == 6'h0E);
    assign imm_nxt = zext ? {{(DATA_W-16){1'b0}}, instr[15:0]}
                          : {{(DATA_W-16){instr[15]}}, instr[15:0]};

    assign pc4        = bus.if_pc + PC_W'(4);
    assign branch_nxt = pc4 + ({{(PC_W-16){instr[15]}}, instr[15:0]} << 2);

    generate
        if (PC_W > 28) begin : g_jump_hi
            assign jump_nxt = {pc4[PC_W-1:28], instr[25:0], 2'b00};
        end else begin : g_jump_lo
            assign jump_nxt = {instr[25:0], 2'b00};
        end
    endgenerate

    assign valid   = (state != ST_EMPTY);
    assign is_load = (state == ST_LOAD);
    assign ld      = !valid || bus.ex_ready;
    assign haz     = is_load && (rt_q != '0) && ((rt_q == rs_a) || (rt_q == rt_a));
    assign ready   = ld && !haz && !bus.flush;
    assign take    = bus.if_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_EMPTY;
        end else if (ld) begin
            if (take) begin
                state_nxt = new_is_load ? ST_LOAD : ST_VALID;
            end else begin
                state_nxt = ST_EMPTY;
            end
        end
    end

    // Payload only moves on an accepted transfer; bubbles and flushes just drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            funct_q   <= '0;
            shamt_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            jump_q    <= '0;
            branch_q  <= '0;
        end else if (take) begin
            opcode_q  <= opc;
            funct_q   <= instr[5:0];
            shamt_q   <= instr[10:6];
            rs_q      <= rs_a;
            rt_q      <= rt_a;
            rd_q      <= rd_a;
            rs_data_q <= rs_cap;
            rt_data_q <= rt_cap;
            imm_q     <= imm_nxt;
            jump_q    <= jump_nxt;
            branch_q  <= branch_nxt;
        end
    end

    assign bus.if_ready   = ready;
    assign bus.id_valid   = valid;
    assign bus.id_opcode  = opcode_q;
    assign bus.id_funct   = funct_q;
    assign bus.id_shamt   = shamt_q;
    assign bus.id_rs      = rs_q;
    assign bus.id_rt      = rt_q;
    assign bus.id_rd      = rd_q;
    assign bus.id_rs_data = rs_data_q;
    assign bus.id_rt_data = rt_data_q;
    assign bus.id_imm     = imm_q;
    assign bus.id_jump    = jump_q;
    assign bus.id_branch  = branch_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus hazard/stall/flush/bypass sequences.
// Expected ID/EX contents are queued at acceptance and compared when execute consumes them.
module tb_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] jump;
        logic [31:0] branch;
        bit          full;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t vecs[7];
    exp_t mon_e;
    exp_t tmp;
    int   st;

    decode_stage_if #(.DATA_W(32), .RA_W(5), .PC_W(32)) bus ();

    decode_stage #(.DATA_W(32), .NUM_REGS(32), .RA_W(5), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] imm, input logic [31:0] jmp,
                                input logic [31:0] br, input bit full);
        exp_t e;
        e.instr = instr; e.pc = pc; e.rs_data = rsd; e.rt_data = rtd;
        e.imm = imm; e.jump = jmp; e.branch = br; e.full = full;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.id_valid && bus.ex_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got instr opcode %h with nothing expected", bus.id_opcode);
            end else begin
                mon_e = sb.pop_front();
                chk("opcode",  32'(bus.id_opcode),  32'(mon_e.instr[31:26]));
                chk("funct",   32'(bus.id_funct),   32'(mon_e.instr[5:0]));
                chk("shamt",   32'(bus.id_shamt),   32'(mon_e.instr[10:6]));
                chk("rs",      32'(bus.id_rs),      32'(mon_e.instr[25:21]));
                chk("rt",      32'(bus.id_rt),      32'(mon_e.instr[20:16]));
                chk("rd",      32'(bus.id_rd),      32'(mon_e.instr[15:11]));
                chk("rs_data", bus.id_rs_data, mon_e.rs_data);
                chk("rt_data", bus.id_rt_data, mon_e.rt_data);
                if (mon_e.full) begin
                    chk("imm",    bus.id_imm,    mon_e.imm);
                    chk("jump",   bus.id_jump,   mon_e.jump);
                    chk("branch", bus.id_branch, mon_e.branch);
                end
            end
        end
    end

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        @(posedge clk); #1;
        bus.wb_en = 1'b0;
    endtask

    task automatic send(input exp_t e, output int stalls);
        stalls = 0;
        bus.if_valid = 1'b1;
        bus.if_instr = e.instr;
        bus.if_pc    = e.pc;
        forever begin
            @(negedge clk);
            if (bus.if_ready) break;
            stalls++;
            if (stalls > 50) break;
            @(posedge clk); #1;
        end
        if (stalls > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: if_ready stayed %b, required 1", bus.if_ready);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.if_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = mk(32'h00A01820, 32'h00001000, 32'h00001234, 32'h0, 32'h00001820, 32'h02806080, 32'h00007084, 1);
        vecs[1] = mk(32'h00053021, 32'h00002000, 32'h0,        32'h00001234, 32'h00003021, 32'h0014C084, 32'h0000E088, 1);
        vecs[2] = mk(32'h1022FFFF, 32'h00400000, 32'h00000100, 32'h00000200, 32'hFFFFFFFF, 32'h008BFFFC, 32'h00400000, 1);
        vecs[3] = mk(32'h34248000, 32'h00400000, 32'h00000100, 32'h0, 32'h00008000, 32'h00920000, 32'h003E0004, 1);
        vecs[4] = mk(32'h08100000, 32'h00400000, 32'h0,        32'h0, 32'h00000000, 32'h00400000, 32'h00400004, 1);
        vecs[5] = mk(32'h3847FFFF, 32'h00000000, 32'h00000200, 32'h0, 32'h0000FFFF, 32'h011FFFFC, 32'h00000000, 1);
        vecs[6] = mk(32'h24088000, 32'hFFFFFFFC, 32'h0,        32'h0, 32'hFFFF8000, 32'h00220000, 32'hFFFE0000, 1);

        rst_n = 1'b0;
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.flush = 1'b0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.ex_ready = 1'b1;
        #12;
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_if_ready", 32'(bus.if_ready), 32'd1);
        chk("rst_rs_data",  bus.id_rs_data, 32'd0);
        chk("rst_imm",      bus.id_imm, 32'd0);
        chk("rst_jump",     bus.id_jump, 32'd0);
        chk("rst_branch",   bus.id_branch, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        wb(5'd5, 32'h00001234);
        wb(5'd0, 32'hFFFFFFFF);
        wb(5'd1, 32'h00000100);
        wb(5'd2, 32'h00000200);

        // Table: first vector also checks the one-cycle latency.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i], st);
            chk("tbl_stall", 32'(st), 32'd0);
            if (i == 0) begin
                chk("latency_valid", 32'(bus.id_valid), 32'd1);
                chk("latency_rd",    32'(bus.id_rd), 32'd3);
            end
        end
        drain();

        // Load-use: lw r2 then add r4,r2,r2 -> one bubble.
        send(mk(32'h8C220000, 32'h10, 32'h100, 32'h200, 0, 0, 0, 0), st);
        bus.if_valid = 1'b1; bus.if_instr = 32'h00422020; bus.if_pc = 32'h14;
        @(negedge clk);
        chk("haz_ready", 32'(bus.if_ready), 32'd0);
        chk("haz_valid", 32'(bus.id_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_valid", 32'(bus.id_valid), 32'd0);
        chk("bubble_ready", 32'(bus.if_ready), 32'd1);
        sb.push_back(mk(32'h00422020, 32'h14, 32'h200, 32'h200, 0, 0, 0, 0));
        @(posedge clk); #1;
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("post_bubble_valid", 32'(bus.id_valid), 32'd1);
        @(posedge clk); #1;

        // Load into r0 never creates a hazard.
        send(mk(32'h8C200000, 32'h20, 32'h100, 32'h0, 0, 0, 0, 0), st);
        bus.if_valid = 1'b1; bus.if_instr = 32'h00002020; bus.if_pc = 32'h24;
        @(negedge clk);
        chk("nohaz_ready", 32'(bus.if_ready), 32'd1);
        sb.push_back(mk(32'h00002020, 32'h24, 32'h0, 32'h0, 0, 0, 0, 0));
        @(posedge clk); #1;
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("nohaz_valid", 32'(bus.id_valid), 32'd1);
        @(posedge clk); #1;
        drain();

        // Back-pressure for three cycles, then flush with a concurrent writeback.
        bus.ex_ready = 1'b0;
        send(vecs[0], st);
        bus.if_valid = 1'b1; bus.if_instr = 32'h00053021; bus.if_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready",   32'(bus.if_ready), 32'd0);
            chk("stall_valid",   32'(bus.id_valid), 32'd1);
            chk("stall_rd",      32'(bus.id_rd), 32'd3);
            chk("stall_rs_data", bus.id_rs_data, 32'h00001234);
            chk("stall_branch",  bus.id_branch, 32'h00007084);
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h00000099;
        @(negedge clk);
        chk("flush_ready", 32'(bus.if_ready), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.wb_en = 1'b0; bus.if_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(bus.id_valid), 32'd0);
        tmp = sb.pop_back();
        bus.ex_ready = 1'b1;
        @(posedge clk); #1;
        send(mk(32'h01205020, 32'h40, 32'h99, 32'h0, 0, 0, 0, 0), st);

        // Same-cycle writeback and read of r7.
        wb(5'd7, 32'h00000077);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h000000AB;
`ifdef RF_BYPASS_EN
        send(mk(32'h00E05820, 32'h50, 32'hAB, 32'h0, 0, 0, 0, 0), st);
`else
        send(mk(32'h00E05820, 32'h50, 32'h77, 32'h0, 0, 0, 0, 0), st);
`endif
        bus.wb_en = 1'b0;
        send(mk(32'h00E05820, 32'h54, 32'hAB, 32'h0, 0, 0, 0, 0), st);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
